// File: rtl/vga_layout_pkg.sv
// Shared definitions for the channel layout sequencer.
//   - default geometry (vertical resolution, first channel row, channel count)
//   - default row/channel index widths
//   - layout FSM state encoding
package vga_layout_pkg;

    localparam int DEFAULT_MAX_CHAN_COUNT = 10;
    localparam int DEFAULT_VER_RES        = 480;
    localparam int DEFAULT_OFFSET         = 0;

    localparam int ROW_W = $clog2(DEFAULT_VER_RES);
    localparam int CH_W  = $clog2(DEFAULT_MAX_CHAN_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COUNT  = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_READY  = 2'd3
    } layout_state_t;

endpackage

// File: rtl/channel_height_divider.sv
// Serial repeated-subtraction divider used to compute rows per channel.
// One subtraction per cycle; a divide of N by D takes floor(N/D)+1 busy cycles.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               begin a division (accepted only when not busy)
//   abort               cancel any division in progress (wins over start)
//   dividend, divisor   operands, sampled on an accepted start
//   busy                division in progress
//   done                one-cycle pulse when quotient is final
//   quotient            result, valid from done until the next start
module channel_height_divider #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    logic [W-1:0] remainder;
    logic [W-1:0] divisor_r;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            divisor_r <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start && !busy) begin
                busy      <= 1'b1;
                remainder <= dividend;
                divisor_r <= divisor;
                quotient  <= '0;
            end else if (busy) begin
                // A zero divisor terminates at once instead of spinning forever.
                if (divisor_r != '0 && remainder >= divisor_r) begin
                    remainder <= remainder - divisor_r;
                    quotient  <= quotient + 1'b1;
                end else begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/channel_layout_sequencer.sv
// Per-frame channel layout for the multi-channel trace display.
// At frame_start the enable mask is latched, enabled channels are counted one
// bit per cycle and the channel height is found by a serial divider. Once
// ready, each row_valid advances row/channel counters so the renderers get
// channel number, height and offset without any per-row arithmetic.
// Ports:
//   clk, reset_n      pixel clock, asynchronous active-low reset
//   channel_enable    enable mask, sampled on frame_start only
//   frame_start       start of vertical blank, restarts the layout
//   row_valid         new row, pixel_row valid in the same cycle
//   pixel_row         row index
//   layout_ready      channel height for this frame is available
//   is_channel        current row belongs to a channel
//   channel_number    physical channel index of the current row
//   channel_height    rows per channel
//   channel_offset    first row of the current channel
//
// state   | meaning
// IDLE    | after reset, no layout yet
// COUNT   | counting enabled mask bits, one per cycle
// DIVIDE  | divider computing rows per channel
// READY   | layout valid, rows are tracked
module channel_layout_sequencer
    import vga_layout_pkg::*;
#(
    parameter int MAX_CHAN_COUNT = DEFAULT_MAX_CHAN_COUNT,
    parameter int VER_RES        = DEFAULT_VER_RES,
    parameter int OFFSET         = DEFAULT_OFFSET
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [MAX_CHAN_COUNT-1:0]     channel_enable,
    input  logic                          frame_start,
    input  logic                          row_valid,
    input  logic [$clog2(VER_RES)-1:0]    pixel_row,
    output logic                          layout_ready,
    output logic                          is_channel,
    output logic [$clog2(MAX_CHAN_COUNT)-1:0] channel_number,
    output logic [$clog2(VER_RES)-1:0]    channel_height,
    output logic [$clog2(VER_RES)-1:0]    channel_offset
);

    localparam int ROW_BITS = $clog2(VER_RES);
    localparam int CH_BITS  = $clog2(MAX_CHAN_COUNT);
    localparam int CNT_BITS = $clog2(MAX_CHAN_COUNT + 1);

    localparam logic [ROW_BITS-1:0] ROW_FIRST = ROW_BITS'(OFFSET);
    localparam logic [ROW_BITS:0]   ROW_END   = (ROW_BITS + 1)'(VER_RES);
    localparam logic [ROW_BITS-1:0] AREA_ROWS = ROW_BITS'(VER_RES - OFFSET);
    localparam logic [CH_BITS-1:0]  LAST_BIT  = CH_BITS'(MAX_CHAN_COUNT - 1);

    layout_state_t               state;
    logic [MAX_CHAN_COUNT-1:0]   mask;
    logic [CH_BITS-1:0]          bit_idx;
    logic [CNT_BITS-1:0]         chan_count;
    logic [CNT_BITS-1:0]         count_next;
    logic [CNT_BITS-1:0]         vis_idx;
    logic [CNT_BITS-1:0]         vis_adv;
    logic [ROW_BITS-1:0]         row_in_ch;
    logic [ROW_BITS-1:0]         row_in_ch_next;
    logic                        div_start;
    logic                        div_busy;
    logic                        div_done;
    logic [ROW_BITS-1:0]         div_quot;
    logic [CH_BITS-1:0]          first_bit;
    logic [CH_BITS-1:0]          next_bit;

    assign count_next     = chan_count + CNT_BITS'(mask[bit_idx]);
    assign div_start      = (state == ST_COUNT) && !frame_start && !div_busy &&
                            (bit_idx == LAST_BIT) && (count_next != '0);
    assign row_in_ch_next = row_in_ch + 1'b1;
    // Visible index saturates at the channel count so the offset never runs
    // past the channel area in the remainder rows.
    assign vis_adv        = (vis_idx < chan_count) ? vis_idx + 1'b1 : vis_idx;

    // Lowest set bit, and lowest set bit above the current channel (holds the
    // current channel when there is none).
    always_comb begin
        first_bit = '0;
        next_bit  = channel_number;
        for (int i = MAX_CHAN_COUNT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_bit = CH_BITS'(i);
                if (i > int'(channel_number)) begin
                    next_bit = CH_BITS'(i);
                end
            end
        end
    end

    channel_height_divider #(
        .W (ROW_BITS)
    ) u_divider (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (div_start),
        .abort    (frame_start),
        .dividend (AREA_ROWS),
        .divisor  (ROW_BITS'(count_next)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            mask           <= '0;
            bit_idx        <= '0;
            chan_count     <= '0;
            vis_idx        <= '0;
            row_in_ch      <= '0;
            layout_ready   <= 1'b0;
            is_channel     <= 1'b0;
            channel_number <= '0;
            channel_height <= '0;
            channel_offset <= '0;
        end else if (frame_start) begin
            state        <= ST_COUNT;
            mask         <= channel_enable;
            bit_idx      <= '0;
            chan_count   <= '0;
            layout_ready <= 1'b0;
            is_channel   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    is_channel <= 1'b0;
                end
                ST_COUNT: begin
                    is_channel <= 1'b0;
                    chan_count <= count_next;
                    bit_idx    <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
                        if (count_next == '0) begin
                            channel_height <= '0;
                            layout_ready   <= 1'b1;
                            state          <= ST_READY;
                        end else begin
                            state <= ST_DIVIDE;
                        end
                    end
                end
                ST_DIVIDE: begin
                    is_channel <= 1'b0;
                    if (div_done) begin
                        channel_height <= div_quot;
                        layout_ready   <= 1'b1;
                        state          <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (row_valid) begin
                        if (pixel_row == ROW_FIRST) begin
                            vis_idx        <= '0;
                            row_in_ch      <= '0;
                            channel_offset <= ROW_FIRST;
                            channel_number <= first_bit;
                            is_channel     <= (chan_count != '0);
                        end else if (pixel_row > ROW_FIRST && {1'b0, pixel_row} < ROW_END) begin
                            if (row_in_ch_next == channel_height) begin
                                row_in_ch <= '0;
                                vis_idx   <= vis_adv;
                                if (vis_idx < chan_count) begin
                                    channel_offset <= channel_offset + channel_height;
                                    channel_number <= next_bit;
                                end
                                is_channel <= (vis_adv < chan_count);
                            end else begin
                                row_in_ch  <= row_in_ch_next;
                                is_channel <= (vis_idx < chan_count);
                            end
                        end else begin
                            is_channel <= 1'b0;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_layout_sequencer.sv
module tb_channel_layout_sequencer;
    import vga_layout_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic [9:0]        channel_enable = '0;
    logic              frame_start = 1'b0;
    logic              row_valid = 1'b0;
    logic [ROW_W-1:0]  pixel_row = '0;

    logic              lr0, ic0, lr1, ic1;
    logic [CH_W-1:0]   num0, num1;
    logic [ROW_W-1:0]  h0, ofs0, h1, ofs1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    channel_layout_sequencer #(.MAX_CHAN_COUNT(10), .VER_RES(480), .OFFSET(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .channel_enable(channel_enable),
        .frame_start(frame_start), .row_valid(row_valid), .pixel_row(pixel_row),
        .layout_ready(lr0), .is_channel(ic0), .channel_number(num0),
        .channel_height(h0), .channel_offset(ofs0));

    channel_layout_sequencer #(.MAX_CHAN_COUNT(10), .VER_RES(480), .OFFSET(32)) dut1 (
        .clk(clk), .reset_n(reset_n), .channel_enable(channel_enable),
        .frame_start(frame_start), .row_valid(row_valid), .pixel_row(pixel_row),
        .layout_ready(lr1), .is_channel(ic1), .channel_number(num1),
        .channel_height(h1), .channel_offset(ofs1));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- layout model ----------------
    function automatic int f_count(input logic [9:0] m);
        int c = 0;
        for (int i = 0; i < 10; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int f_height(input logic [9:0] m, input int off);
        int c = f_count(m);
        return (c == 0) ? 0 : (480 - off) / c;
    endfunction

    function automatic int f_nth(input logic [9:0] m, input int n);
        int seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (m[i]) begin
                if (seen == n) return i;
                seen++;
            end
        end
        return -1;
    endfunction

    // Counting takes one cycle per mask bit; division takes quotient+1 cycles.
    function automatic int f_lat_min(input logic [9:0] m, input int off);
        return (f_count(m) == 0) ? 10 : 10 + f_height(m, off) + 1;
    endfunction

    function automatic int f_lat_max(input logic [9:0] m, input int off);
        return (f_count(m) == 0) ? 10 : 10 + f_height(m, off) + 2;
    endfunction

    bit         have_frame = 1'b0;
    logic [9:0] m_mask = '0;
    int         fs_cnt = 0;
    bit         cap_rv = 1'b0, cap_fs = 1'b0;
    int         cap_row = 0;
    bit         cap_rdy0 = 1'b0, cap_rdy1 = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            have_frame <= 1'b0;
            m_mask     <= '0;
            fs_cnt     <= 0;
            cap_rv     <= 1'b0;
            cap_fs     <= 1'b0;
            cap_row    <= 0;
            cap_rdy0   <= 1'b0;
            cap_rdy1   <= 1'b0;
        end else begin
            cap_rv   <= row_valid;
            cap_fs   <= frame_start;
            cap_row  <= int'(pixel_row);
            cap_rdy0 <= have_frame && fs_cnt >= f_lat_max(m_mask, 0);
            cap_rdy1 <= have_frame && fs_cnt >= f_lat_max(m_mask, 32);
            if (frame_start) begin
                have_frame <= 1'b1;
                m_mask     <= channel_enable;
                fs_cnt     <= 0;
            end else if (fs_cnt < 1000000) begin
                fs_cnt <= fs_cnt + 1;
            end
        end
    end

    int c_off, c_lr, c_ic, c_num, c_h, c_ofs, c_cnt, c_q, c_vis;
    bit c_rdy;

    always @(negedge clk) begin
        if (reset_n) begin
            for (int d = 0; d < 2; d++) begin
                c_off = (d == 0) ? 0 : 32;
                if (d == 0) begin
                    c_lr = int'(lr0); c_ic = int'(ic0); c_num = int'(num0);
                    c_h = int'(h0); c_ofs = int'(ofs0); c_rdy = cap_rdy0;
                end else begin
                    c_lr = int'(lr1); c_ic = int'(ic1); c_num = int'(num1);
                    c_h = int'(h1); c_ofs = int'(ofs1); c_rdy = cap_rdy1;
                end
                c_cnt = f_count(m_mask);
                c_q   = f_height(m_mask, c_off);
                if (!have_frame) begin
                    chk($sformatf("ready_idle[%0d]", d), c_lr, 0);
                end else if (fs_cnt < f_lat_min(m_mask, c_off)) begin
                    chk($sformatf("ready_busy[%0d]", d), c_lr, 0);
                end else if (fs_cnt >= f_lat_max(m_mask, c_off)) begin
                    chk($sformatf("ready_done[%0d]", d), c_lr, 1);
                    chk($sformatf("height[%0d]", d), c_h, c_q);
                end
                if (cap_rv) begin
                    if (cap_fs || !c_rdy) begin
                        chk($sformatf("row_not_ready[%0d] row %0d", d, cap_row), c_ic, 0);
                    end else if (cap_row < c_off || cap_row >= 480 || c_cnt == 0) begin
                        chk($sformatf("row_outside[%0d] row %0d", d, cap_row), c_ic, 0);
                    end else begin
                        c_vis = (cap_row - c_off) / c_q;
                        if (c_vis >= c_cnt) begin
                            chk($sformatf("row_remainder[%0d] row %0d", d, cap_row), c_ic, 0);
                        end else begin
                            chk($sformatf("row_in[%0d] row %0d", d, cap_row), c_ic, 1);
                            chk($sformatf("row_chan[%0d] row %0d", d, cap_row), c_num, f_nth(m_mask, c_vis));
                            chk($sformatf("row_offset[%0d] row %0d", d, cap_row), c_ofs, c_off + c_vis * c_q);
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_fs(input logic [9:0] m, input bit with_row, input int r);
        @(negedge clk);
        frame_start    = 1'b1;
        channel_enable = m;
        row_valid      = with_row;
        pixel_row      = ROW_W'(r);
        @(negedge clk);
        frame_start = 1'b0;
        row_valid   = 1'b0;
    endtask

    task automatic scan(input int a, input int b);
        for (int r = a; r <= b; r++) begin
            @(negedge clk);
            row_valid = 1'b1;
            pixel_row = ROW_W'(r);
        end
        @(negedge clk);
        row_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!(lr0 && lr1) && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'({lr0, lr1}), 3);
    endtask

    task automatic chk_zero(input string name);
        chk({name, " lr0"}, int'(lr0), 0);   chk({name, " lr1"}, int'(lr1), 0);
        chk({name, " ic0"}, int'(ic0), 0);   chk({name, " ic1"}, int'(ic1), 0);
        chk({name, " num0"}, int'(num0), 0); chk({name, " num1"}, int'(num1), 0);
        chk({name, " h0"}, int'(h0), 0);     chk({name, " h1"}, int'(h1), 0);
        chk({name, " ofs0"}, int'(ofs0), 0); chk({name, " ofs1"}, int'(ofs1), 0);
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        scan(5, 5);
        chk("idle_row ic0", int'(ic0), 0);

        // three channels: height 160
        do_fs(10'b0000100101, 1'b0, 0);
        wait_ready("ready_3ch");
        chk("h_3ch", int'(h0), 160);
        scan(0, 159);
        chk("r159 ic", int'(ic0), 1); chk("r159 ch", int'(num0), 0); chk("r159 ofs", int'(ofs0), 0);
        scan(160, 160);
        chk("r160 ch", int'(num0), 2); chk("r160 ofs", int'(ofs0), 160);
        scan(161, 320);
        chk("r320 ch", int'(num0), 5); chk("r320 ofs", int'(ofs0), 320);
        scan(321, 479);

        // reset while dividing: outputs clear at once, FSM idle afterwards
        do_fs(10'b0000100101, 1'b0, 0);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1 chk_zero("reset_mid_divide");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        scan(0, 3);
        chk("post_reset lr0", int'(lr0), 0);

        // seven channels: height 68, remainder rows at the bottom
        do_fs(10'b0001111111, 1'b0, 0);
        wait_ready("ready_7ch");
        chk("h_7ch", int'(h0), 68);
        scan(0, 475);
        chk("r475 ic", int'(ic0), 1); chk("r475 ch", int'(num0), 6); chk("r475 ofs", int'(ofs0), 408);
        scan(476, 479);
        chk("r479 ic", int'(ic0), 0);

        // empty mask: ready right after counting
        do_fs(10'b0, 1'b0, 0);
        repeat (9) @(negedge clk);
        chk("empty lr early", int'(lr0), 0);
        @(negedge clk);
        chk("empty lr", int'(lr0), 1);
        chk("empty h", int'(h0), 0);
        scan(0, 479);

        // mask change without frame_start has no effect
        do_fs(10'b1, 1'b0, 0);
        wait_ready("ready_1ch");
        scan(0, 479);
        channel_enable = 10'b11;
        scan(0, 479);
        chk("stale h", int'(h0), 480);
        chk("stale ic", int'(ic0), 1); chk("stale ch", int'(num0), 0); chk("stale ofs", int'(ofs0), 0);

        // frame_start wins over a simultaneous row; restart during divide
        do_fs(10'b11, 1'b1, 0);
        chk("fs_and_row ic", int'(ic0), 0);
        scan(0, 4);
        repeat (15) @(negedge clk);
        do_fs(10'b11, 1'b0, 0);
        wait_ready("ready_2ch");
        chk("h_2ch", int'(h0), 240);
        chk("h_2ch off32", int'(h1), 224);
        scan(0, 240);
        chk("r240 ch", int'(num0), 1); chk("r240 ofs", int'(ofs0), 240);
        scan(241, 479);

        // all channels, OFFSET=32 instance: height 44
        do_fs(10'h3FF, 1'b0, 0);
        wait_ready("ready_10ch");
        chk("h_10ch off32", int'(h1), 44);
        scan(0, 31);
        chk("r31 ic1", int'(ic1), 0);
        scan(32, 32);
        chk("r32 ic1", int'(ic1), 1); chk("r32 ch1", int'(num1), 0); chk("r32 ofs1", int'(ofs1), 32);
        scan(33, 471);
        chk("r471 ch1", int'(num1), 9); chk("r471 ofs1", int'(ofs1), 428);
        scan(472, 472);
        chk("r472 ic1", int'(ic1), 0);
        chk("r472 ic0", int'(ic0), 1); chk("r472 ofs0", int'(ofs0), 432);
        scan(473, 479);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
